// File: rtl/sint_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sint_issue_ctrl
// Purpose  : Front-end issue controller for scene_int. Merges primary-ray
//            generator (PRG) rays and shader rays into one registered
//            output slot, gates issue on downstream credits, drives the
//            scene_int_pl stage valids and runs the frame-end drain sequence.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            prg_valid/data/stall - PRG ray input and hold request
//            sh_valid/data/stall  - shader ray input and hold request
//            out_valid/data/stall - registered ray to scene_int
//            ret                  - one credit returned this cycle
//            v0, v1, v2           - scene_int_pl stage valids
//            flush / drained      - drain request / drain complete
//            err                  - sticky credit-overflow flag
// Revision : 1.0 - initial release
// ============================================================================
module sint_issue_ctrl #(
  parameter int DATA_W     = 200,
  parameter int CREDITS    = 18,
  parameter int CW         = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prg_valid,
  input  logic [DATA_W-1:0] prg_data,
  output logic              prg_stall,
  input  logic              sh_valid,
  input  logic [DATA_W-1:0] sh_data,
  output logic              sh_stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_stall,
  input  logic              ret,
  output logic              v0,
  output logic              v1,
  output logic              v2,
  input  logic              flush,
  output logic              drained,
  output logic              err
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  localparam logic [CW-1:0] c_credits    = CW'(CREDITS);
  localparam logic [SW-1:0] c_starve_max = SW'(STARVE_MAX);

  localparam logic [1:0] c_st_normal = 2'd0;
  localparam logic [1:0] c_st_drain  = 2'd1;
  localparam logic [1:0] c_st_done   = 2'd2;

  logic [1:0]        r_state;
  logic [CW-1:0]     r_credits;
  logic [SW-1:0]     r_starve_cnt;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_v0;
  logic              r_v1;
  logic              r_v2;
  logic              r_drained;
  logic              r_err;

  logic              w_accept;
  logic              w_slot_free;
  logic              w_can_load;
  logic              w_gnt_prg;
  logic              w_gnt_sh;
  logic              w_load;
  logic [DATA_W-1:0] w_load_data;
  logic [1:0]        w_state_nxt;

  // The output slot can take a new ray when empty or being emptied this cycle.
  assign w_accept    = r_out_valid & ~out_stall;
  assign w_slot_free = ~r_out_valid | w_accept;
  // Grants are suppressed during reset so both stalls simply mirror valid.
  assign w_can_load  = w_slot_free & (r_credits != '0) & ~rst;

  always_comb begin
    w_gnt_prg = 1'b0;
    w_gnt_sh  = 1'b0;
    if (w_can_load) begin
      if (r_state == c_st_normal) begin
        // Shader rays normally win; a PRG starved for STARVE_MAX shader
        // grants in a row is forced through once.
        if (prg_valid && (r_starve_cnt == c_starve_max)) begin
          w_gnt_prg = 1'b1;
        end else if (sh_valid) begin
          w_gnt_sh = 1'b1;
        end else if (prg_valid) begin
          w_gnt_prg = 1'b1;
        end
      end else if (sh_valid) begin
        // While draining, new primary rays are held off; shader rays of
        // the current frame still need to complete.
        w_gnt_sh = 1'b1;
      end
    end
  end

  assign w_load      = w_gnt_prg | w_gnt_sh;
  assign w_load_data = w_gnt_prg ? prg_data : sh_data;

  assign prg_stall = prg_valid & ~w_gnt_prg;
  assign sh_stall  = sh_valid & ~w_gnt_sh;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_normal: begin
        if (flush) w_state_nxt = c_st_drain;
      end
      c_st_drain: begin
        if (!flush) begin
          w_state_nxt = c_st_normal;
        end else if ((r_credits == c_credits) && !r_out_valid && !sh_valid) begin
          // All credits home and nothing pending: pipeline is empty.
          w_state_nxt = c_st_done;
        end
      end
      c_st_done: begin
        if (!flush) begin
          w_state_nxt = c_st_normal;
        end else if (w_gnt_sh) begin
          // A late shader ray re-opens the drain.
          w_state_nxt = c_st_drain;
        end
      end
      default: w_state_nxt = c_st_normal;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_st_normal;
      r_credits    <= c_credits;
      r_starve_cnt <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_v0         <= 1'b0;
      r_v1         <= 1'b0;
      r_v2         <= 1'b0;
      r_drained    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_drained <= (w_state_nxt == c_st_done);

      r_v0 <= w_accept;
      r_v1 <= r_v0;
      r_v2 <= r_v1;

      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_load_data;
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
      end

      if (w_gnt_prg || !prg_valid) begin
        r_starve_cnt <= '0;
      end else if (w_gnt_sh && (r_starve_cnt != c_starve_max)) begin
        r_starve_cnt <= r_starve_cnt + SW'(1);
      end

      // A load and a return in the same cycle cancel out.
      case ({w_load, ret})
        2'b10: r_credits <= r_credits - CW'(1);
        2'b01: begin
          if (r_credits == c_credits) begin
            r_err <= 1'b1;
          end else begin
            r_credits <= r_credits + CW'(1);
          end
        end
        default: r_credits <= r_credits;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign v0        = r_v0;
  assign v1        = r_v1;
  assign v2        = r_v2;
  assign drained   = r_drained;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sint_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sint_issue_ctrl
// Purpose  : Self-checking bench for sint_issue_ctrl. A behavioural model
//            predicts grants, stalls and registered outputs; granted rays go
//            into a scoreboard queue that a separate monitor drains whenever
//            the DUT hands a ray to scene_int.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sint_issue_ctrl;

  localparam int DW = 64;
  localparam int CR = 18;
  localparam int CWD = 5;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          prg_valid;
  logic [DW-1:0] prg_data;
  logic          prg_stall;
  logic          sh_valid;
  logic [DW-1:0] sh_data;
  logic          sh_stall;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_stall;
  logic          ret;
  logic          v0;
  logic          v1;
  logic          v2;
  logic          flush;
  logic          drained;
  logic          err;

  always #5 clk = ~clk;

  sint_issue_ctrl #(
    .DATA_W(DW), .CREDITS(CR), .CW(CWD), .STARVE_MAX(SM)
  ) dut (
    .clk(clk), .rst(rst),
    .prg_valid(prg_valid), .prg_data(prg_data), .prg_stall(prg_stall),
    .sh_valid(sh_valid), .sh_data(sh_data), .sh_stall(sh_stall),
    .out_valid(out_valid), .out_data(out_data), .out_stall(out_stall),
    .ret(ret), .v0(v0), .v1(v1), .v2(v2),
    .flush(flush), .drained(drained), .err(err)
  );

  int checks = 0;
  int errors = 0;
  bit m_known = 1'b0;

  // Reference model state (plain integers, spec-level view)
  int            m_cred;
  int            m_starve;
  int            m_mode;     // 0 normal, 1 draining, 2 drained
  bit            m_ov;
  logic [DW-1:0] m_od;
  bit            m_vpipe [3];
  bit            m_err;
  logic [DW-1:0] sb [$];
  int            dut_g;      // grant observed on DUT this cycle: 0 none, 1 PRG, 2 shader

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cred = CR; m_starve = 0; m_mode = 0; m_ov = 0; m_od = '0;
    m_vpipe[0] = 0; m_vpipe[1] = 0; m_vpipe[2] = 0; m_err = 0;
    sb.delete();
  endtask

  // Compare the DUT against the model for the current cycle, then advance the model.
  task automatic mstep();
    bit acc, can, gp, gs;
    int nmode;
    acc = m_ov && !out_stall;
    can = (!m_ov || acc) && (m_cred > 0) && !rst;
    gp = 0; gs = 0;
    if (can) begin
      if (m_mode == 0) begin
        if (prg_valid && m_starve == SM) gp = 1;
        else if (sh_valid) gs = 1;
        else if (prg_valid) gp = 1;
      end else if (sh_valid) begin
        gs = 1;
      end
    end
    chk1("prg_stall", prg_stall, logic'(prg_valid && !gp));
    chk1("sh_stall", sh_stall, logic'(sh_valid && !gs));
    chk1("out_valid", out_valid, m_ov);
    if (m_ov) chkd("out_data", out_data, m_od);
    chk1("v0", v0, m_vpipe[0]);
    chk1("v1", v1, m_vpipe[1]);
    chk1("v2", v2, m_vpipe[2]);
    chk1("drained", drained, logic'(m_mode == 2));
    chk1("err", err, m_err);

    if (rst) begin
      model_reset();
      return;
    end
    nmode = m_mode;
    if (m_mode == 0 && flush) nmode = 1;
    else if (m_mode == 1 && !flush) nmode = 0;
    else if (m_mode == 1 && m_cred == CR && !m_ov && !sh_valid) nmode = 2;
    else if (m_mode == 2 && !flush) nmode = 0;
    else if (m_mode == 2 && gs) nmode = 1;
    m_mode = nmode;

    m_vpipe[2] = m_vpipe[1]; m_vpipe[1] = m_vpipe[0]; m_vpipe[0] = acc;
    if (gp || gs) begin
      m_ov = 1;
      m_od = gp ? prg_data : sh_data;
      sb.push_back(m_od);
    end else if (acc) begin
      m_ov = 0;
    end
    if (gp || !prg_valid) m_starve = 0;
    else if (gs && m_starve < SM) m_starve++;
    if ((gp || gs) && !ret) m_cred--;
    else if (!(gp || gs) && ret) begin
      if (m_cred == CR) m_err = 1;
      else m_cred++;
    end
  endtask

  // One clock cycle: drive inputs, check mid-cycle, advance to just after the edge.
  task automatic cyc(input bit pv, input bit sv, input bit os, input bit r, input bit fl, input bit rs);
    prg_valid = pv; sh_valid = sv; out_stall = os; ret = r; flush = fl; rst = rs;
    prg_data = {$urandom, $urandom};
    sh_data  = {$urandom, $urandom};
    #2;
    dut_g = (prg_valid && !prg_stall) ? 1 : ((sh_valid && !sh_stall) ? 2 : 0);
    mstep();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: each ray taken by scene_int must be the oldest outstanding grant.
  always @(negedge clk) begin
    if (m_known && !rst && out_valid && !out_stall) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty: got ray %h expected no ray at %0t", out_data, $time);
      end else begin
        chkd("sb_data", out_data, sb.pop_front());
      end
    end
  end

  initial begin
    int cnt;
    bit fl_r;
    rst = 1; prg_valid = 0; sh_valid = 0; out_stall = 0; ret = 0; flush = 0;
    prg_data = '0; sh_data = '0;
    model_reset();
    @(posedge clk); #1;
    m_known = 1;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 1);   // valids during reset must just stall

    // PRG only, no returns: credits run out after 18 issues
    cyc(0, 0, 0, 0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      if (dut_g == 1) cnt++;
    end
    chki("prg_issue_count", cnt, 18);
    cyc(1, 0, 0, 1, 0, 0);
    chki("ret_same_cycle_no_issue", dut_g, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chki("ret_then_issue", dut_g, 1);
    cyc(1, 0, 0, 0, 0, 0);
    chki("ret_only_one_issue", dut_g, 0);

    // Both sources busy with ample credits: SH,SH,SH,SH,PRG repeating
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 0, 1, 0, 0);
      chki("arb_pattern", dut_g, (i % 5 == 4) ? 1 : 2);
    end

    // Output held by scene_int for 5 cycles, then released
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 1, 0, 0, 0);
      chki("stall_no_grant", dut_g, 0);
    end
    cyc(0, 0, 0, 0, 0, 0);
    chk1("v0_pulse", v0, 1'b1);
    cyc(0, 0, 0, 0, 0, 0);
    chk1("v1_pulse", v1, 1'b1);
    cyc(0, 0, 0, 0, 0, 0);
    chk1("v2_pulse", v2, 1'b1);

    // Load and return together at credits=3 leaves 3 credits
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      if (dut_g == 1) cnt++;
    end
    chki("credits_after_load_ret", cnt, 3);

    // Spurious return with all credits home
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0);
    chk1("err_set", err, 1'b1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
    chk1("err_sticky", err, 1'b1);

    // Flush with 6 rays in flight
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0, 1, 0);
      if (dut_g == 1) cnt++;
    end
    cyc(1, 1, 0, 0, 1, 0);
    chki("drain_shader_served", dut_g, 2);
    for (int i = 0; i < 7; i++) begin
      cyc(1, 0, 0, 1, 1, 0);
      if (dut_g == 1) cnt++;
    end
    chki("drain_no_prg", cnt, 0);
    for (int i = 0; i < 8 && !drained; i++) cyc(1, 0, 0, 0, 1, 0);
    chk1("drained_rise", drained, 1'b1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chki("prg_resumes", dut_g, 1);

    // Randomized traffic against the model
    fl_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) fl_r = !fl_r;
      cyc(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0),
          bit'($urandom_range(0, 3) == 0),
          bit'((m_cred < CR) && ($urandom_range(0, 1) == 1)),
          fl_r, bit'($urandom_range(0, 499) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
